// File: rtl/dense_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : dense_accumulator
// Purpose : Sums N_IN dual-rail product vectors per lane, emits dual-rail sums.
// Revision: 1.0
// ============================================================================
module dense_accumulator #(
    parameter int BIT_DATA = 8,
    parameter int KSIZE    = 4,
    parameter int N_IN     = 16,
    parameter int BIT_ACC  = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2*BIT_DATA*KSIZE-1:0] xt,
    input  logic [2*BIT_DATA*KSIZE-1:0] xf,
    output logic                        ack_prev,
    output logic [BIT_ACC*KSIZE-1:0]    yt,
    output logic [BIT_ACC*KSIZE-1:0]    yf,
    input  logic                        ack_nxt,
    output logic                        err,
    output logic [15:0]                 cnt
);

    localparam int          c_bitm = 2 * BIT_DATA;
    localparam logic [15:0] c_n_in = 16'(N_IN);

    typedef enum logic [1:0] {
        S_WAIT_DATA = 2'd0,
        S_WAIT_NULL = 2'd1,
        S_EMIT      = 2'd2,
        S_RTZ       = 2'd3
    } state_t;

    state_t                       r_state;
    logic [BIT_ACC-1:0]           r_acc [KSIZE];
    logic [15:0]                  r_cnt;
    logic                         r_ack_prev;
    logic                         r_err;
    logic [BIT_ACC*KSIZE-1:0]     r_yt;
    logic [BIT_ACC*KSIZE-1:0]     r_yf;

    logic                         w_complete;
    logic                         w_null;
    logic                         w_illegal;
    logic [BIT_ACC-1:0]           w_prod_ext [KSIZE];
    logic [BIT_ACC*KSIZE-1:0]     w_acc_flat;

    // Anything that is none of these three is a partially arrived codeword.
    assign w_complete = (xf == ~xt);
    assign w_null     = (xt == '0) && (xf == '0);
    assign w_illegal  = |(xt & xf);

    for (genvar g = 0; g < KSIZE; g++) begin : g_lane
        assign w_prod_ext[g] = {{(BIT_ACC - c_bitm){xt[c_bitm*(g+1)-1]}},
                                xt[c_bitm*g +: c_bitm]};
        assign w_acc_flat[BIT_ACC*g +: BIT_ACC] = r_acc[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_WAIT_DATA;
            r_cnt      <= '0;
            r_ack_prev <= 1'b0;
            r_err      <= 1'b0;
            r_yt       <= '0;
            r_yf       <= '0;
            for (int i = 0; i < KSIZE; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            case (r_state)
                S_WAIT_DATA: begin
                    if (w_complete) begin
                        for (int i = 0; i < KSIZE; i++) begin
                            r_acc[i] <= r_acc[i] + w_prod_ext[i];
                        end
                        r_cnt      <= r_cnt + 16'd1;
                        r_ack_prev <= 1'b1;
                        r_state    <= S_WAIT_NULL;
                    end else if (w_illegal) begin
                        r_err <= 1'b1;
                    end
                end
                S_WAIT_NULL: begin
                    if (w_null) begin
                        r_ack_prev <= 1'b0;
                        if (r_cnt == c_n_in) begin
                            r_yt    <= w_acc_flat;
                            r_yf    <= ~w_acc_flat;
                            r_state <= S_EMIT;
                        end else begin
                            r_state <= S_WAIT_DATA;
                        end
                    end
                end
                S_EMIT: begin
                    // Upstream stays unacknowledged until the sum is retired.
                    if (ack_nxt) begin
                        r_yt    <= '0;
                        r_yf    <= '0;
                        r_state <= S_RTZ;
                    end
                end
                S_RTZ: begin
                    if (!ack_nxt) begin
                        for (int i = 0; i < KSIZE; i++) begin
                            r_acc[i] <= '0;
                        end
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DATA;
                    end
                end
                default: r_state <= S_WAIT_DATA;
            endcase
        end
    end

    assign ack_prev = r_ack_prev;
    assign yt       = r_yt;
    assign yf       = r_yf;
    assign err      = r_err;
    assign cnt      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dense_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_dense_accumulator
// Purpose : Randomized self-checking bench for dense_accumulator (N_IN=4).
// Revision: 1.0
// ============================================================================
module tb_dense_accumulator;

    localparam int BD = 8;
    localparam int KS = 4;
    localparam int NI = 4;
    localparam int BA = 20;
    localparam int BM = 2 * BD;

    logic              clk = 1'b0;
    logic              reset;
    logic [BM*KS-1:0]  xt;
    logic [BM*KS-1:0]  xf;
    logic              ack_prev;
    logic [BA*KS-1:0]  yt;
    logic [BA*KS-1:0]  yf;
    logic              ack_nxt;
    logic              err;
    logic [15:0]       cnt;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint model_sum [KS];

    dense_accumulator #(
        .BIT_DATA (BD),
        .KSIZE    (KS),
        .N_IN     (NI),
        .BIT_ACC  (BA)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .xt       (xt),
        .xf       (xf),
        .ack_prev (ack_prev),
        .yt       (yt),
        .yf       (yf),
        .ack_nxt  (ack_nxt),
        .err      (err),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int l = 0; l < KS; l++) model_sum[l] = 0;
    endfunction

    function automatic void model_add(input logic [BM*KS-1:0] v);
        for (int l = 0; l < KS; l++) begin
            model_sum[l] += longint'($signed(v[l*BM +: BM]));
        end
    endfunction

    function automatic logic [BM*KS-1:0] rand_vec();
        logic [BM*KS-1:0] v;
        v = {$urandom, $urandom};
        return v;
    endfunction

    // Full four-phase upstream handshake for one product vector.
    task automatic send_token(input logic [BM*KS-1:0] v, output bit ok);
        bit rose;
        bit fell;
        rose = 1'b0;
        fell = 1'b0;
        xt = v;
        xf = ~v;
        for (int t = 0; t < 20 && !rose; t++) begin
            tick();
            rose = ack_prev;
        end
        xt = '0;
        xf = '0;
        for (int t = 0; t < 20 && rose && !fell; t++) begin
            tick();
            fell = !ack_prev;
        end
        ok = rose && fell;
    endtask

    // Waits for a valid sum, captures it, then runs the downstream handshake.
    task automatic get_result(output bit ok, output logic [BA*KS-1:0] ryt,
                              output logic [BA*KS-1:0] ryf);
        bit gone;
        ok   = 1'b0;
        gone = 1'b0;
        ryt  = '0;
        ryf  = '0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (yt != '0 || yf != '0) ok = 1'b1;
            else tick();
        end
        ryt = yt;
        ryf = yf;
        ack_nxt = 1'b1;
        for (int t = 0; t < 20 && !gone; t++) begin
            tick();
            gone = (yt == '0) && (yf == '0);
        end
        ack_nxt = 1'b0;
        ok = ok && gone;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; xt = '0; xf = '0; ack_nxt = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        n_tests++; if (ack_prev !== 1'b0) begin n_fail++; $display("FAIL reset_ack_prev: got %b, required 0", ack_prev); end
        n_tests++; if (yt !== '0) begin n_fail++; $display("FAIL reset_yt: got %h, required 0", yt); end
        n_tests++; if (yf !== '0) begin n_fail++; $display("FAIL reset_yf: got %h, required 0", yf); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
        n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d, required 0", cnt); end
    endtask

    task automatic test_constant();
        bit ok;
        int handshakes;
        logic [BA*KS-1:0] ryt, ryf;
        handshakes = 0;
        for (int k = 0; k < NI; k++) begin
            send_token({KS{16'h0003}}, ok);
            if (ok) handshakes++;
            n_tests++;
            if (cnt !== 16'(k + 1)) begin n_fail++; $display("FAIL const_cnt: got %0d, required %0d", cnt, k + 1); end
        end
        n_tests++;
        if (handshakes != NI) begin n_fail++; $display("FAIL const_handshakes: got %0d, required %0d", handshakes, NI); end
        get_result(ok, ryt, ryf);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL const_result_timeout: got 0, required 1"); end
        for (int l = 0; l < KS; l++) begin
            n_tests++;
            if (ryt[l*BA +: BA] !== 20'd12 || ryf[l*BA +: BA] !== 20'hFFFF3) begin
                n_fail++;
                $display("FAIL const_lane%0d: got yt=%h yf=%h, required yt=0000c yf=ffff3", l, ryt[l*BA +: BA], ryf[l*BA +: BA]);
            end
        end
    endtask

    task automatic test_signed();
        bit ok;
        int vals [NI];
        logic [BM*KS-1:0] v;
        logic [BA*KS-1:0] ryt, ryf;
        longint s;
        vals[0] = -100; vals[1] = 50; vals[2] = -30; vals[3] = 1;
        model_clear();
        for (int k = 0; k < NI; k++) begin
            v = rand_vec();
            v[BM-1:0] = 16'(vals[k]);
            model_add(v);
            send_token(v, ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL signed_handshake: got 0, required 1"); end
        end
        get_result(ok, ryt, ryf);
        n_tests++;
        if (ryt[BA-1:0] !== 20'hFFFB1 || ryf[BA-1:0] !== 20'h0004E) begin
            n_fail++;
            $display("FAIL signed_lane0: got yt=%h yf=%h, required yt=fffb1 yf=0004e", ryt[BA-1:0], ryf[BA-1:0]);
        end
        for (int l = 1; l < KS; l++) begin
            s = model_sum[l];
            n_tests++;
            if (ryt[l*BA +: BA] !== s[BA-1:0] || ryf[l*BA +: BA] !== ~s[BA-1:0]) begin
                n_fail++;
                $display("FAIL signed_lane%0d: got yt=%h yf=%h, required yt=%h", l, ryt[l*BA +: BA], ryf[l*BA +: BA], s[BA-1:0]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [BM*KS-1:0] v;
        logic [BA*KS-1:0] ryt, ryf;
        longint s;
        for (int r = 0; r < 3; r++) begin
            model_clear();
            for (int k = 0; k < NI; k++) begin
                v = rand_vec();
                model_add(v);
                send_token(v, ok);
            end
            get_result(ok, ryt, ryf);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL random_result_timeout: got 0, required 1"); end
            for (int l = 0; l < KS; l++) begin
                s = model_sum[l];
                n_tests++;
                if (ryt[l*BA +: BA] !== s[BA-1:0] || ryf[l*BA +: BA] !== ~s[BA-1:0]) begin
                    n_fail++;
                    $display("FAIL random_lane%0d: got yt=%h yf=%h, required yt=%h", l, ryt[l*BA +: BA], ryf[l*BA +: BA], s[BA-1:0]);
                end
            end
        end
    endtask

    task automatic test_mixed();
        bit ok;
        bit fell;
        logic [BM*KS-1:0] v;
        logic [BA*KS-1:0] ryt, ryf;
        longint s;
        model_clear();
        xt = 64'h0000_0000_FFFF_FFFF;
        xf = '0;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_tests++;
            if (ack_prev !== 1'b0) begin n_fail++; $display("FAIL mixed_no_ack: got %b, required 0", ack_prev); end
        end
        v = rand_vec();
        model_add(v);
        xt = v;
        xf = ~v;
        tick();
        n_tests++;
        if (ack_prev !== 1'b1) begin n_fail++; $display("FAIL mixed_ack_rise: got %b, required 1", ack_prev); end
        n_tests++;
        if (cnt !== 16'd1) begin n_fail++; $display("FAIL mixed_cnt: got %0d, required 1", cnt); end
        xt = '0;
        xf = '0;
        fell = 1'b0;
        for (int t = 0; t < 20 && !fell; t++) begin tick(); fell = !ack_prev; end
        for (int k = 1; k < NI; k++) begin
            v = rand_vec();
            model_add(v);
            send_token(v, ok);
        end
        get_result(ok, ryt, ryf);
        for (int l = 0; l < KS; l++) begin
            s = model_sum[l];
            n_tests++;
            if (ryt[l*BA +: BA] !== s[BA-1:0] || ryf[l*BA +: BA] !== ~s[BA-1:0]) begin
                n_fail++;
                $display("FAIL mixed_lane%0d: got yt=%h, required yt=%h", l, ryt[l*BA +: BA], s[BA-1:0]);
            end
        end
    endtask

    task automatic test_illegal();
        bit ok;
        logic [BM*KS-1:0] v;
        logic [BA*KS-1:0] ryt, ryf;
        longint s;
        model_clear();
        v = rand_vec();
        model_add(v);
        send_token(v, ok);
        xt = 64'h0000_0000_FFFF_0000;
        xf = 64'h0000_0000_FFFF_0000;
        tick();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b, required 1", err); end
        n_tests++; if (cnt !== 16'd1) begin n_fail++; $display("FAIL illegal_cnt: got %0d, required 1", cnt); end
        n_tests++; if (ack_prev !== 1'b0) begin n_fail++; $display("FAIL illegal_ack: got %b, required 0", ack_prev); end
        xt = '0;
        xf = '0;
        tick();
        for (int k = 1; k < NI; k++) begin
            v = rand_vec();
            model_add(v);
            send_token(v, ok);
        end
        get_result(ok, ryt, ryf);
        for (int l = 0; l < KS; l++) begin
            s = model_sum[l];
            n_tests++;
            if (ryt[l*BA +: BA] !== s[BA-1:0] || ryf[l*BA +: BA] !== ~s[BA-1:0]) begin
                n_fail++;
                $display("FAIL illegal_lane%0d: got yt=%h, required yt=%h", l, ryt[l*BA +: BA], s[BA-1:0]);
            end
        end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b, required 1", err); end
    endtask

    task automatic test_back_pressure();
        bit ok;
        bit seen;
        logic [BM*KS-1:0] v;
        logic [BA*KS-1:0] ryt, ryf, cap_t, cap_f;
        longint s;
        model_clear();
        for (int k = 0; k < NI; k++) begin
            v = rand_vec();
            model_add(v);
            send_token(v, ok);
        end
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (yt != '0 || yf != '0) seen = 1'b1;
            else tick();
        end
        cap_t = yt;
        cap_f = yf;
        for (int l = 0; l < KS; l++) begin
            s = model_sum[l];
            n_tests++;
            if (cap_t[l*BA +: BA] !== s[BA-1:0] || cap_f[l*BA +: BA] !== ~s[BA-1:0]) begin
                n_fail++;
                $display("FAIL bp_lane%0d: got yt=%h, required yt=%h", l, cap_t[l*BA +: BA], s[BA-1:0]);
            end
        end
        model_clear();
        v = rand_vec();
        xt = v;
        xf = ~v;
        for (int t = 0; t < 10; t++) begin
            tick();
            n_tests++;
            if (yt !== cap_t || yf !== cap_f || ack_prev !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got yt=%h ack_prev=%b, required yt=%h ack_prev=0", yt, ack_prev, cap_t);
            end
        end
        ack_nxt = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin tick(); seen = (yt == '0) && (yf == '0); end
        n_tests++;
        if (!seen || ack_prev !== 1'b0 || cnt !== 16'(NI)) begin
            n_fail++;
            $display("FAIL bp_rtz: got null=%b ack_prev=%b cnt=%0d, required null=1 ack_prev=0 cnt=%0d", seen, ack_prev, cnt, NI);
        end
        ack_nxt = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin tick(); seen = ack_prev; end
        n_tests++;
        if (!seen || cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_first_token: got ack=%b cnt=%0d, required ack=1 cnt=1", seen, cnt);
        end
        model_add(v);
        xt = '0;
        xf = '0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin tick(); seen = !ack_prev; end
        for (int k = 1; k < NI; k++) begin
            v = rand_vec();
            model_add(v);
            send_token(v, ok);
        end
        get_result(ok, ryt, ryf);
        for (int l = 0; l < KS; l++) begin
            s = model_sum[l];
            n_tests++;
            if (ryt[l*BA +: BA] !== s[BA-1:0] || ryf[l*BA +: BA] !== ~s[BA-1:0]) begin
                n_fail++;
                $display("FAIL bp_fresh_lane%0d: got yt=%h, required yt=%h", l, ryt[l*BA +: BA], s[BA-1:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        logic [BM*KS-1:0] v;
        logic [BA*KS-1:0] ryt, ryf;
        longint s;
        send_token(rand_vec(), ok);
        v = rand_vec();
        xt = v;
        xf = ~v;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin tick(); seen = ack_prev; end
        n_tests++;
        if (!seen || cnt !== 16'd2) begin n_fail++; $display("FAIL rstmid_setup: got ack=%b cnt=%0d, required ack=1 cnt=2", seen, cnt); end
        reset = 1'b1;
        xt = '0;
        xf = '0;
        tick();
        reset = 1'b0;
        n_tests++;
        if (ack_prev !== 1'b0 || cnt !== 16'd0 || yt !== '0 || yf !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got ack=%b cnt=%0d yt=%h yf=%h err=%b, required all 0", ack_prev, cnt, yt, yf, err);
        end
        model_clear();
        for (int k = 0; k < NI; k++) begin
            v = rand_vec();
            model_add(v);
            send_token(v, ok);
        end
        get_result(ok, ryt, ryf);
        for (int l = 0; l < KS; l++) begin
            s = model_sum[l];
            n_tests++;
            if (ryt[l*BA +: BA] !== s[BA-1:0] || ryf[l*BA +: BA] !== ~s[BA-1:0]) begin
                n_fail++;
                $display("FAIL rstmid_lane%0d: got yt=%h, required yt=%h", l, ryt[l*BA +: BA], s[BA-1:0]);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        xt      = '0;
        xf      = '0;
        ack_nxt = 1'b0;
        test_reset();
        test_constant();
        test_signed();
        test_random();
        test_mixed();
        test_illegal();
        test_back_pressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
